alu_vmac_execute: RTL and testbench

- Execute-stage datapath directly downstream of the ALU control decoder. Consumes its 5-bit ALU operation code plus two 32-bit operands, and produces a registered result and a branch-taken flag.
- Scalar and branch ops complete in 1 cycle.
- VMAC (code 5'b10000) is a multi-cycle packed signed-8-bit multiply-accumulate used by the FIR core. It runs one lane per cycle into a persistent accumulator and stalls upstream through ready_in.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_vmac_execute_lane_mul.sv | 28 ++
 rtl/alu_vmac_execute.sv | 158 +++++++++++++++
 tb/tb_alu_vmac_execute.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: op codes, decoder control classes, VMAC FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

    // Operation codes produced by the ALU control decoder
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;
    localparam logic [4:0] ALU_BEQ  = 5'b01010;
    localparam logic [4:0] ALU_BNE  = 5'b01011;
    localparam logic [4:0] ALU_BLT  = 5'b01100;
    localparam logic [4:0] ALU_BGE  = 5'b01101;
    localparam logic [4:0] ALU_BLTU = 5'b01110;
    localparam logic [4:0] ALU_BGEU = 5'b01111;
    localparam logic [4:0] ALU_VMAC = 5'b10000;

    // ALU control class codes shared with the decoder
    localparam logic [2:0] LoadStoreType  = 3'b000;
    localparam logic [2:0] JTypeALU       = 3'b001;
    localparam logic [2:0] ITypeJALR_ALU  = 3'b010;
    localparam logic [2:0] UTypeALU       = 3'b011;
    localparam logic [2:0] UTypeAUIPC_ALU = 3'b100;
    localparam logic [2:0] BTypeALU       = 3'b101;
    localparam logic [2:0] RTypeALU       = 3'b110;
    localparam logic [2:0] ITypeALU       = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } vmac_state_t;

endpackage

// File: rtl/alu_vmac_execute_lane_mul.sv
// Selects one signed lane from each operand and multiplies, sign-extended to accumulator width.
// Latency: combinational.
// Backpressure: none; purely combinational.
module vmac_lane_mul #(
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int SEL_W      = 2
) (
    input  logic [LANES*LANE_WIDTH-1:0] a,
    input  logic [LANES*LANE_WIDTH-1:0] b,
    input  logic [SEL_W-1:0]            lane,
    output logic [ACC_WIDTH-1:0]        prod
);

    logic signed [LANE_WIDTH-1:0]   a_lane;
    logic signed [LANE_WIDTH-1:0]   b_lane;
    logic signed [2*LANE_WIDTH-1:0] p;

    // Lane k occupies bits [k*LANE_WIDTH +: LANE_WIDTH]; lane 0 is the low byte
    always_comb begin
        a_lane = LANE_WIDTH'(a >> (lane * LANE_WIDTH));
        b_lane = LANE_WIDTH'(b >> (lane * LANE_WIDTH));
        p      = a_lane * b_lane;
        prod   = {{(ACC_WIDTH-2*LANE_WIDTH){p[2*LANE_WIDTH-1]}}, p};
    end

endmodule

// File: rtl/alu_vmac_execute.sv
// Execute stage: scalar/branch ALU ops plus multi-cycle packed signed VMAC into a persistent accumulator.
// Latency: scalar/branch/illegal 1 cycle; VMAC LANES+1 cycles from accept to valid_out.
// Backpressure: ready_in low while a VMAC is in flight; flush aborts it or drops the input.
module alu_vmac_execute
    import alu_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [4:0]  alu_op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        acc_clear,
    input  logic        flush,
    output logic        valid_out,
    output logic [31:0] result,
    output logic        branch_taken,
    output logic        illegal_op
);

    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;

    vmac_state_t          state, state_nxt;
    logic [SEL_W-1:0]     lane;
    logic [31:0]          op_a, op_b;
    logic [ACC_WIDTH-1:0] acc, psum, lane_prod, sum_nxt;
    logic                 xfer_vld, vmac_start, last_lane;
    logic [31:0]          alu_res;
    logic                 br_res, op_bad;

    assign ready_in   = (state == IDLE);
    assign xfer_vld   = valid_in && ready_in && !flush;
    assign vmac_start = xfer_vld && (alu_op == ALU_VMAC);
    assign last_lane  = (lane == SEL_W'(LANES - 1));
    assign sum_nxt    = psum + lane_prod;

    vmac_lane_mul #(
        .LANES      (LANES),
        .LANE_WIDTH (LANE_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SEL_W      (SEL_W)
    ) u_lane_mul (
        .a    (op_a),
        .b    (op_b),
        .lane (lane),
        .prod (lane_prod)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: enter MAC on VMAC accept, leave after last lane or on flush
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vmac_start) state_nxt = MAC;
            MAC:     if (flush || last_lane) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle scalar/branch evaluation; branch ops also report taken as the result
    always_comb begin
        alu_res = '0;
        br_res  = 1'b0;
        op_bad  = 1'b0;
        case (alu_op)
            ALU_ADD:  alu_res = operand_a + operand_b;
            ALU_SUB:  alu_res = operand_a - operand_b;
            ALU_AND:  alu_res = operand_a & operand_b;
            ALU_OR:   alu_res = operand_a | operand_b;
            ALU_XOR:  alu_res = operand_a ^ operand_b;
            ALU_SLL:  alu_res = operand_a << operand_b[4:0];
            ALU_SRL:  alu_res = operand_a >> operand_b[4:0];
            ALU_SRA:  alu_res = $unsigned($signed(operand_a) >>> operand_b[4:0]);
            ALU_SLT:  alu_res = {31'b0, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: alu_res = {31'b0, operand_a < operand_b};
            ALU_BEQ:  br_res  = (operand_a == operand_b);
            ALU_BNE:  br_res  = (operand_a != operand_b);
            ALU_BLT:  br_res  = ($signed(operand_a) <  $signed(operand_b));
            ALU_BGE:  br_res  = ($signed(operand_a) >= $signed(operand_b));
            ALU_BLTU: br_res  = (operand_a <  operand_b);
            ALU_BGEU: br_res  = (operand_a >= operand_b);
            ALU_VMAC: op_bad  = 1'b0;
            default:  op_bad  = 1'b1;
        endcase
        if (alu_op >= ALU_BEQ && alu_op <= ALU_BGEU) alu_res = {31'b0, br_res};
    end

    // VMAC datapath: operand latch, lane walk, accumulator commit; flush leaves acc untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane <= '0;
            acc  <= '0;
            psum <= '0;
            op_a <= '0;
            op_b <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (vmac_start) begin
                        op_a <= operand_a;
                        op_b <= operand_b;
                        psum <= acc_clear ? '0 : acc;
                        lane <= '0;
                    end else if (acc_clear) begin
                        acc <= '0;
                    end
                end
                MAC: begin
                    if (flush) begin
                        psum <= '0;
                        lane <= '0;
                    end else if (last_lane) begin
                        acc  <= sum_nxt;
                        lane <= '0;
                    end else begin
                        psum <= sum_nxt;
                        lane <= lane + SEL_W'(1);
                    end
                end
                default: lane <= '0;
            endcase
        end
    end

    // Registered outputs; valid_out and illegal_op are one-cycle pulses, result holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out    <= 1'b0;
            result       <= '0;
            branch_taken <= 1'b0;
            illegal_op   <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            illegal_op <= 1'b0;
            if (xfer_vld && alu_op != ALU_VMAC) begin
                valid_out    <= 1'b1;
                result       <= alu_res;
                branch_taken <= br_res;
                illegal_op   <= op_bad;
            end else if (state == MAC && !flush && last_lane) begin
                valid_out    <= 1'b1;
                result       <= sum_nxt[31:0];
                branch_taken <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_vmac_execute.sv
module tb_alu_vmac_execute;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_in;
    logic [4:0]  alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        acc_clear;
    logic        flush;
    logic        valid_out;
    logic [31:0] result;
    logic        branch_taken;
    logic        illegal_op;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_acc = 32'd0;

    alu_vmac_execute dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .alu_op       (alu_op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .acc_clear    (acc_clear),
        .flush        (flush),
        .valid_out    (valid_out),
        .result       (result),
        .branch_taken (branch_taken),
        .illegal_op   (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference semantics of the single-cycle ops
    function automatic void model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic t, output logic il);
        longint sa, sb;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        r = 32'd0; t = 1'b0; il = 1'b0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = a << sh;
            5'd6:  r = a >> sh;
            5'd7:  r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd9:  r = (a < b) ? 32'd1 : 32'd0;
            5'd10: t = (a == b);
            5'd11: t = (a != b);
            5'd12: t = (sa < sb);
            5'd13: t = (sa >= sb);
            5'd14: t = (a < b);
            5'd15: t = (a >= b);
            default: il = 1'b1;
        endcase
        if (op >= 5'd10 && op <= 5'd15) r = {31'b0, t};
    endfunction

    // Dot product of the four signed bytes, wrapped to 32 bits
    function automatic logic [31:0] lane_dot(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            byte xa, xb;
            xa = a[i*8 +: 8];
            xb = b[i*8 +: 8];
            s += int'(xa) * int'(xb);
        end
        return s;
    endfunction

    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic clr);
        logic [31:0] er;
        logic        et, ei;
        model_op(op, a, b, er, et, ei);
        check("op_ready", 32'(ready_in), 32'd1);
        valid_in = 1'b1; alu_op = op; operand_a = a; operand_b = b; acc_clear = clr;
        step();
        valid_in = 1'b0; acc_clear = 1'b0;
        if (clr) model_acc = 32'd0;
        check($sformatf("op%0d_valid", op), 32'(valid_out), 32'd1);
        check($sformatf("op%0d_result a=%h b=%h", op, a, b), result, er);
        check($sformatf("op%0d_taken", op), 32'(branch_taken), 32'(et));
        check($sformatf("op%0d_illegal", op), 32'(illegal_op), 32'(ei));
    endtask

    task automatic do_vmac(input logic [31:0] a, input logic [31:0] b, input logic clr);
        logic [31:0] ev;
        ev = (clr ? 32'd0 : model_acc) + lane_dot(a, b);
        check("vmac_ready_in", 32'(ready_in), 32'd1);
        valid_in = 1'b1; alu_op = 5'b10000; operand_a = a; operand_b = b; acc_clear = clr;
        step();
        valid_in = 1'b0; acc_clear = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("vmac_busy_ready", 32'(ready_in), 32'd0);
            check("vmac_busy_valid", 32'(valid_out), 32'd0);
            step();
        end
        check("vmac_valid", 32'(valid_out), 32'd1);
        check($sformatf("vmac_result a=%h b=%h", a, b), result, ev);
        check("vmac_taken", 32'(branch_taken), 32'd0);
        check("vmac_illegal", 32'(illegal_op), 32'd0);
        check("vmac_ready_back", 32'(ready_in), 32'd1);
        model_acc = ev;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [4:0]  rop;
        rst_n = 1'b0; valid_in = 1'b0; alu_op = 5'd0; operand_a = 32'd0; operand_b = 32'd0;
        acc_clear = 1'b0; flush = 1'b0;
        step(); step();
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_taken", 32'(branch_taken), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        check("rst_ready", 32'(ready_in), 32'd1);
        rst_n = 1'b1;
        step();

        do_op(5'd0, 32'd5, 32'd7, 1'b0);
        check("add_const", result, 32'd12);
        do_op(5'd1, 32'd5, 32'd7, 1'b0);
        check("sub_const", result, 32'hFFFF_FFFE);
        do_op(5'd7, 32'h8000_0000, 32'd4, 1'b0);
        check("sra_const", result, 32'hF800_0000);
        do_op(5'd6, 32'h8000_0000, 32'd4, 1'b0);
        check("srl_const", result, 32'h0800_0000);
        do_op(5'd12, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("blt_const", 32'(branch_taken), 32'd1);
        check("blt_res_const", result, 32'd1);
        do_op(5'd14, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("bltu_const", 32'(branch_taken), 32'd0);
        step();
        check("idle_no_valid", 32'(valid_out), 32'd0);
        check("result_holds", result, 32'd0);

        // Standalone clear, then two accumulating VMACs (second back-to-back with a scalar)
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        model_acc = 32'd0;
        do_vmac(32'h0102_0304, 32'h0506_0708, 1'b0);
        check("vmac1_const", result, 32'd70);
        do_vmac(32'hFFFF_FFFF, 32'h0101_0101, 1'b0);
        check("vmac2_const", result, 32'd66);
        do_op(5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);

        // Flush mid-MAC: no result, accumulator keeps its pre-VMAC value
        valid_in = 1'b1; alu_op = 5'b10000; operand_a = 32'h7F7F_7F7F; operand_b = 32'h7F7F_7F7F;
        step();
        valid_in = 1'b0;
        check("fl_c1_valid", 32'(valid_out), 32'd0);
        step();
        flush = 1'b1;
        check("fl_c2_valid", 32'(valid_out), 32'd0);
        step();
        flush = 1'b0;
        check("fl_c3_ready", 32'(ready_in), 32'd1);
        check("fl_c3_valid", 32'(valid_out), 32'd0);
        step();
        check("fl_c4_valid", 32'(valid_out), 32'd0);
        do_vmac(32'd0, 32'd0, 1'b0);
        check("fl_acc_kept", result, 32'd66);

        // Flush in IDLE drops the transfer
        valid_in = 1'b1; alu_op = 5'd0; operand_a = 32'd1; operand_b = 32'd2; flush = 1'b1;
        step();
        valid_in = 1'b0; flush = 1'b0;
        check("idle_flush_drop", 32'(valid_out), 32'd0);
        check("idle_flush_ready", 32'(ready_in), 32'd1);

        // Inputs and acc_clear offered while busy are ignored
        valid_in = 1'b1; alu_op = 5'b10000; operand_a = 32'h0000_0203; operand_b = 32'h0000_0405;
        step();
        for (int k = 1; k <= 4; k++) begin
            check("busy_ready", 32'(ready_in), 32'd0);
            valid_in = (k < 4); alu_op = 5'd0; acc_clear = (k < 4);
            step();
        end
        acc_clear = 1'b0;
        model_acc = model_acc + 32'd23;
        check("busy_vmac_valid", 32'(valid_out), 32'd1);
        check("busy_vmac_result", result, model_acc);
        step();
        check("busy_no_extra", 32'(valid_out), 32'd0);

        // Reset during MAC cycle 3
        valid_in = 1'b1; alu_op = 5'b10000; operand_a = 32'h0102_0304; operand_b = 32'h0506_0708;
        step();
        valid_in = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_acc = 32'd0;
        check("mrst_valid", 32'(valid_out), 32'd0);
        check("mrst_result", result, 32'd0);
        check("mrst_taken", 32'(branch_taken), 32'd0);
        check("mrst_illegal", 32'(illegal_op), 32'd0);
        check("mrst_ready", 32'(ready_in), 32'd1);
        do_vmac(32'd0, 32'd0, 1'b0);
        check("mrst_acc_zero", result, 32'd0);
        do_op(5'b10101, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        check("illegal_const", 32'(illegal_op), 32'd1);
        check("illegal_res_const", result, 32'd0);
        step();
        check("illegal_pulse", 32'(illegal_op), 32'd0);

        // Randomized mix against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = 5'($urandom_range(0, 31));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if (rop == 5'b10000) do_vmac(ra, rb, ($urandom_range(0, 3) == 0));
            else                 do_op(rop, ra, rb, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) step();
        end
        do_vmac(32'h0301_FF80, 32'h7F02_0180, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
